// File: rtl/ep0_in_sequencer.sv
// EP0 IN data-stage sequencer: streams min(src_len, req_len) descriptor bytes
// into MAX_PKT packets with DATA0/DATA1 toggling, ZLP termination and retransmit.
//
// Byte handshake: a byte is transferred on every cycle where tx_valid and
// tx_ready are both high; tx_valid, tx_data, tx_last and rom_addr hold steady
// while tx_ready is low, and the next byte appears the cycle after acceptance.
module ep0_in_sequencer #(
  parameter int MAX_PKT = 64,
  parameter int ADDR_W  = 8
) (
  input  logic              clk48,
  input  logic              reset,
  input  logic              bus_reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       src_len,
  input  logic [15:0]       req_len,
  input  logic              abort,
  input  logic              in_token,
  input  logic              handshake_ack,
  input  logic              handshake_timeout,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              tx_start,
  output logic [6:0]        tx_len,
  output logic              tx_data1,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT_IN = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd2;
  localparam logic [2:0] S_WAIT_HS = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [15:0] MAX16    = 16'(MAX_PKT);
  localparam logic [15:0] PKT_MASK = 16'(MAX_PKT - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0]       offset_q, offset_d;
  logic [15:0]       remaining_q, remaining_d;
  logic              zlp_needed_q, zlp_needed_d;
  logic              toggle_q, toggle_d;
  logic [6:0]        byte_idx_q, byte_idx_d;
  logic              tx_start_q, tx_start_d;
  logic [6:0]        tx_len_q, tx_len_d;
  logic              tx_data1_q, tx_data1_d;

  logic        clear;
  logic [15:0] total_c;
  logic [15:0] rem_next_c;
  logic [6:0]  pkt_len_c;
  logic        tx_valid_c;
  logic        tx_last_c;

  assign clear      = reset | bus_reset | abort;
  assign total_c    = (src_len < req_len) ? src_len : req_len;
  assign pkt_len_c  = (remaining_q < MAX16) ? remaining_q[6:0] : 7'(MAX_PKT);
  assign rem_next_c = remaining_q - 16'(tx_len_q);
  // A ZLP has tx_len_q == 0, so it never raises tx_valid.
  assign tx_valid_c = (state_q == S_SEND) && (byte_idx_q < tx_len_q);
  assign tx_last_c  = tx_valid_c && (byte_idx_q == tx_len_q - 7'd1);

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    offset_d     = offset_q;
    remaining_d  = remaining_q;
    zlp_needed_d = zlp_needed_q;
    toggle_d     = toggle_q;
    byte_idx_d   = byte_idx_q;
    tx_start_d   = 1'b0;
    tx_len_d     = tx_len_q;
    tx_data1_d   = tx_data1_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d       = base_addr;
          offset_d     = 16'd0;
          remaining_d  = total_c;
          zlp_needed_d = (total_c < req_len) && ((total_c & PKT_MASK) == 16'd0);
          toggle_d     = 1'b1;
          state_d      = S_WAIT_IN;
        end
      end
      S_WAIT_IN: begin
        if (in_token) begin
          tx_start_d = 1'b1;
          tx_len_d   = pkt_len_c;
          tx_data1_d = toggle_q;
          byte_idx_d = 7'd0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_len_q == 7'd0) begin
          state_d = S_WAIT_HS;
        end else if (tx_valid_c && tx_ready) begin
          if (tx_last_c) begin
            byte_idx_d = 7'd0;
            state_d    = S_WAIT_HS;
          end else begin
            byte_idx_d = byte_idx_q + 7'd1;
          end
        end
      end
      S_WAIT_HS: begin
        if (handshake_ack) begin
          offset_d    = offset_q + 16'(tx_len_q);
          remaining_d = rem_next_c;
          toggle_d    = ~toggle_q;
          // The only zero-length packet of a transfer with zlp_needed is the ZLP itself.
          if ((rem_next_c == 16'd0) && (!zlp_needed_q || (tx_len_q == 7'd0))) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_IN;
          end
        end else if (handshake_timeout) begin
          state_d = S_WAIT_IN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk48) begin
    if (clear) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      offset_q     <= 16'd0;
      remaining_q  <= 16'd0;
      zlp_needed_q <= 1'b0;
      toggle_q     <= 1'b0;
      byte_idx_q   <= 7'd0;
      tx_start_q   <= 1'b0;
      tx_len_q     <= 7'd0;
      tx_data1_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      offset_q     <= offset_d;
      remaining_q  <= remaining_d;
      zlp_needed_q <= zlp_needed_d;
      toggle_q     <= toggle_d;
      byte_idx_q   <= byte_idx_d;
      tx_start_q   <= tx_start_d;
      tx_len_q     <= tx_len_d;
      tx_data1_q   <= tx_data1_d;
    end
  end

  assign rom_addr = base_q + ADDR_W'(offset_q) + ADDR_W'(byte_idx_q);
  assign tx_start = tx_start_q;
  assign tx_len   = tx_len_q;
  assign tx_data1 = tx_data1_q;
  assign tx_data  = rom_data;
  assign tx_valid = tx_valid_c;
  assign tx_last  = tx_last_c;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_ep0_in_sequencer.sv
// Randomized scoreboard bench for ep0_in_sequencer: a host driver plays IN
// tokens and handshakes, a negedge monitor checks every packet header and beat.
module tb_ep0_in_sequencer;
  localparam int MAX_PKT = 64;
  localparam int ADDR_W  = 8;

  // clock / reset
  logic clk48 = 1'b0;
  always #10 clk48 = ~clk48;

  logic              reset = 1'b1;
  logic              bus_reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [15:0]       src_len = 16'd0;
  logic [15:0]       req_len = 16'd0;
  logic              abort = 1'b0;
  logic              in_token = 1'b0;
  logic              handshake_ack = 1'b0;
  logic              handshake_timeout = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              tx_start;
  logic [6:0]        tx_len;
  logic              tx_data1;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic              tx_last;
  logic              busy;
  logic              done;

  logic [7:0] rom [256];
  assign rom_data = rom[rom_addr];

  ep0_in_sequencer #(.MAX_PKT(MAX_PKT), .ADDR_W(ADDR_W)) dut (
    .clk48(clk48), .reset(reset), .bus_reset(bus_reset), .start(start),
    .base_addr(base_addr), .src_len(src_len), .req_len(req_len), .abort(abort),
    .in_token(in_token), .handshake_ack(handshake_ack),
    .handshake_timeout(handshake_timeout), .rom_addr(rom_addr), .rom_data(rom_data),
    .tx_start(tx_start), .tx_len(tx_len), .tx_data1(tx_data1), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy),
    .done(done)
  );

  // scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];   // {last, addr, data}
  logic [7:0]  hdr_q[$];   // {data1, len}
  int starts_seen = 0;
  int beats_acc = 0;
  int done_cnt = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic [7:0] cur_hdr = 8'd0;
  bit strict = 1'b0;
  bit ready_hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk48);
    #1;
  endtask

  // encoder-side back-pressure
  initial begin
    forever begin
      @(posedge clk48);
      #1;
      tx_ready = ready_hold ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // monitor
  always @(negedge clk48) begin
    logic [7:0]  h;
    logic [16:0] e;
    cyc++;
    if (tx_start) begin
      starts_seen++;
      start_cyc = cyc;
      if (hdr_q.size() == 0) begin
        chk("extra_tx_start", {31'd0, tx_start}, 32'd0);
      end else begin
        h = hdr_q.pop_front();
        cur_hdr = h;
        chk("tx_len", {25'd0, tx_len}, {25'd0, h[6:0]});
        chk("tx_data1", {31'd0, tx_data1}, {31'd0, h[7]});
      end
    end
    if (tx_valid && tx_ready) begin
      beats_acc++;
      if (exp_q.size() == 0) begin
        chk("extra_beat", {31'd0, tx_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rom_addr", {24'd0, rom_addr}, {24'd0, e[15:8]});
        chk("tx_data", {24'd0, tx_data}, {24'd0, e[7:0]});
        chk("tx_last", {31'd0, tx_last}, {31'd0, e[16]});
        chk("tx_len_stable", {25'd0, tx_len}, {25'd0, cur_hdr[6:0]});
        chk("tx_data1_stable", {31'd0, tx_data1}, {31'd0, cur_hdr[7]});
        if (strict && e[16])
          chk("zero_bubble", cyc - start_cyc, {25'd0, cur_hdr[6:0]} - 1);
      end
    end
    if (done) done_cnt++;
  end

  // one complete data stage driven by the host; to_once forces one timeout on packet to_idx
  task automatic run_xfer(input int base, input int src, input int req, input int to_pct,
                          input int to_idx, input bit inject_start);
    int total;
    bit zlp;
    int lens[$];
    int off;
    int idx;
    int len;
    int pd;
    int ps;
    int pb;
    int k;
    bit ok;
    bit to;
    bit to_used;
    bit first;
    logic [7:0] a;
    total = (src < req) ? src : req;
    zlp = (total < req) && (total % MAX_PKT == 0);
    for (int r = total; r > 0; r -= MAX_PKT) lens.push_back((r < MAX_PKT) ? r : MAX_PKT);
    if (zlp || lens.size() == 0) lens.push_back(0);
    pd = done_cnt;
    off = 0;
    idx = 0;
    to_used = 1'b0;
    first = 1'b1;
    start = 1'b1;
    base_addr = 8'(base);
    src_len = 16'(src);
    req_len = 16'(req);
    step();
    start = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    while (idx < lens.size()) begin
      len = lens[idx];
      hdr_q.push_back({(idx % 2 == 0), 7'(len)});
      for (int i = 0; i < len; i++) begin
        a = 8'(base + off + i);
        exp_q.push_back({(i == len - 1), a, rom[a]});
      end
      ps = starts_seen;
      pb = beats_acc;
      step();
      in_token = 1'b1;
      step();
      in_token = 1'b0;
      if (inject_start && first) begin
        start = 1'b1;
        base_addr = 8'($urandom);
        src_len = 16'd7;
        req_len = 16'd7;
        step();
        start = 1'b0;
      end
      first = 1'b0;
      ok = 1'b0;
      for (k = 0; k < 2000; k++) begin
        @(posedge clk48);
        if (starts_seen > ps && beats_acc >= pb + len) begin
          ok = 1'b1;
          break;
        end
      end
      chk("packet_complete", {31'd0, ok}, 32'd1);
      if (!ok) return;
      #1;
      to = ($urandom_range(0, 99) < to_pct) || (idx == to_idx && !to_used);
      if (idx == to_idx) to_used = 1'b1;
      if (to) begin
        handshake_timeout = 1'b1;
      end else begin
        handshake_ack = 1'b1;
        handshake_timeout = ($urandom_range(0, 3) == 0);
      end
      step();
      handshake_ack = 1'b0;
      handshake_timeout = 1'b0;
      if (!to) begin
        off += len;
        idx++;
      end
    end
    ok = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(posedge clk48);
      if (done_cnt > pd) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    chk("done_count", done_cnt, pd + 1);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    chk("beats_left", exp_q.size(), 32'd0);
  endtask

  // cancel a transfer mid-packet via abort or bus_reset
  task automatic abort_xfer(input bit use_bus_reset);
    int pd;
    int pb;
    bit ok;
    logic [7:0] a;
    pd = done_cnt;
    start = 1'b1;
    base_addr = 8'd40;
    src_len = 16'd200;
    req_len = 16'd200;
    step();
    start = 1'b0;
    hdr_q.push_back({1'b1, 7'd64});
    for (int i = 0; i < 64; i++) begin
      a = 8'(40 + i);
      exp_q.push_back({(i == 63), a, rom[a]});
    end
    pb = beats_acc;
    step();
    in_token = 1'b1;
    step();
    in_token = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk48);
      if (beats_acc >= pb + 5) begin
        ok = 1'b1;
        break;
      end
    end
    chk("abort_reach_send", {31'd0, ok}, 32'd1);
    #1;
    if (use_bus_reset) bus_reset = 1'b1;
    else abort = 1'b1;
    step();
    abort = 1'b0;
    bus_reset = 1'b0;
    exp_q.delete();
    hdr_q.delete();
    chk("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("abort_tx_start", {31'd0, tx_start}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (10) step();
    chk("abort_no_done", done_cnt, pd);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    repeat (3) step();
    reset = 1'b0;
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_last", {31'd0, tx_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_tx_len", {25'd0, tx_len}, 32'd0);
    chk("rst_tx_data1", {31'd0, tx_data1}, 32'd0);
    chk("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
    step();

    // short descriptor, streaming with tx_ready held high
    ready_hold = 1'b1;
    strict = 1'b1;
    step();
    run_xfer(0, 18, 64, 0, -1, 1'b0);
    strict = 1'b0;
    ready_hold = 1'b0;

    run_xfer(16, 128, 255, 0, -1, 1'b0);   // 64, 64, ZLP
    run_xfer(0, 200, 100, 0, -1, 1'b0);    // 64, 36
    run_xfer(0, 200, 100, 0, 1, 1'b1);     // second packet retransmitted
    abort_xfer(1'b0);
    run_xfer(0, 30, 30, 0, -1, 1'b0);
    abort_xfer(1'b1);
    run_xfer(250, 10, 10, 0, -1, 1'b0);    // address wrap
    run_xfer(3, 0, 8, 0, -1, 1'b0);        // single ZLP
    run_xfer(3, 0, 0, 0, -1, 1'b0);
    run_xfer(7, 64, 64, 0, 0, 1'b0);       // exact multiple, no ZLP

    for (int t = 0; t < 12; t++) begin
      run_xfer($urandom_range(0, 255), $urandom_range(0, 300), $urandom_range(0, 300),
               25, -1, bit'($urandom_range(0, 1)));
    end

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
